// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial sequencer around an external single-bit full-adder cell. It takes
// a WIDTH-bit addition request (a, b, cin) over a valid/ready handshake. It then
// feeds the cell one operand bit pair per cycle, LSB first, and keeps the ripple
// carry in a flip-flop between bits. It gathers the cell's sum bits and returns
// {cout, sum} = a + b + cin over a second valid/ready handshake.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous reset, ACTIVE-HIGH despite the name
//   ena        global enable; 0 freezes all state and blocks both handshakes
//   in_valid   request valid          in_ready   request ready (IDLE & ena & ~rst_n)
//   a, b, cin  operands, captured only on an accepted request
//   out_valid  result valid (DONE & ena)
//   out_ready  result consumer ready
//   sum, cout  registered result
//   busy       operation in flight (state != IDLE)
//   fa_a/fa_b/fa_cin  drive the full-adder cell (0 outside RUN)
//   fa_sum/fa_cout    outputs of the full-adder cell
// -----------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the upper WIDTH-1 collected sum bits need storage: the newest bit
  // comes straight from the cell and the LSB would be shifted out anyway.
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             in_fire;
  logic             out_fire;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign s_nxt    = {fa_sum, s_sh};

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire)  state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE) & ena & ~rst_n;
    out_valid = (state == DONE) & ena;
    busy      = (state != IDLE);
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    if (state == RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry_q;
    end
  end

  // Datapath: operand shifters, carry flop, sum collector and result register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
            s_sh    <= '0;
          end
        end
        RUN: begin
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh    <= s_nxt[WIDTH-1:1];
          carry_q <= fa_cout;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= s_nxt;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  always #5 clk = ~clk;

  // Behavioural full-adder cell
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH:0] exp_q[$];
  int             cyc = 0;
  bit             b2b = 1'b0;
  int             last_out = -1;

  always @(posedge clk) cyc++;

  // Scoreboard: push on accepted request, pop on completed result handshake
  always @(negedge clk) begin
    if (rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
      if (out_valid && out_ready) begin
        check("pending_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0)
          check("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
        if (b2b) begin
          if (last_out >= 0) check("spacing", 64'(cyc - last_out), 64'(10));
          last_out = cyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
  endtask

  task automatic accept_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    wait_ready();
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check("out_valid_wait", 64'(out_valid), 64'(1));
  endtask

  initial begin
    int             n;
    logic [WIDTH-1:0] fa_a_seq;
    logic [WIDTH-1:0] fa_cin_seq;
    logic [2:0]     fa_hold;
    logic           seen;

    rst_n = 1'b1; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("in_ready_in_reset", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_fa", 64'({fa_a, fa_b, fa_cin}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Basic add, latency
    accept_op(8'h3C, 8'h42, 1'b0);
    wait_valid(n);
    check("t1_latency", 64'(n), 64'(8));
    check("t1_sum", 64'(sum), 64'(8'h7E));
    check("t1_cout", 64'(cout), 64'(0));
    step();

    // Cell drive sequence
    accept_op(8'h5A, 8'hA5, 1'b1);
    for (int k = 0; k < WIDTH; k++) begin
      fa_a_seq[k] = fa_a;
      fa_cin_seq[k] = fa_cin;
      step();
    end
    check("t2_out_valid", 64'(out_valid), 64'(1));
    check("t2_fa_a_seq", 64'(fa_a_seq), 64'(8'h5A));
    check("t2_fa_cin_seq", 64'(fa_cin_seq), 64'(8'hFF));
    check("t2_sum", 64'(sum), 64'(8'h00));
    check("t2_cout", 64'(cout), 64'(1));
    step();

    // Output back-pressure
    out_ready = 1'b0;
    accept_op(8'hFF, 8'h01, 1'b0);
    wait_valid(n);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", 64'(out_valid), 64'(1));
      check("t3_hold_result", 64'({cout, sum}), 64'(9'h100));
      check("t3_in_ready", 64'(in_ready), 64'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    check("t3_idle", 64'(busy), 64'(0));

    // Enable stall mid-run
    accept_op(8'h0F, 8'h01, 1'b0);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n++;
    end
    ena = 1'b0;
    fa_hold = {fa_a, fa_b, fa_cin};
    for (int k = 0; k < 3; k++) begin
      step();
      n++;
      check("t4_fa_frozen", 64'({fa_a, fa_b, fa_cin}), 64'(fa_hold));
      check("t4_busy", 64'(busy), 64'(1));
      check("t4_no_valid", 64'(out_valid), 64'(0));
    end
    ena = 1'b1;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check("t4_latency", 64'(n), 64'(11));
    check("t4_result", 64'({cout, sum}), 64'(9'h010));
    step();

    // Abort by reset
    accept_op(8'h12, 8'h34, 1'b0);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_sum", 64'(sum), 64'(0));
    check("t5_cout", 64'(cout), 64'(0));
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen |= out_valid;
      step();
    end
    check("t5_no_valid_pulse", 64'(seen), 64'(0));
    accept_op(8'h01, 8'h01, 1'b0);
    wait_valid(n);
    check("t5_new_sum", 64'(sum), 64'(8'h02));
    check("t5_new_cout", 64'(cout), 64'(0));
    step();

    // Back-to-back random traffic
    b2b = 1'b1;
    last_out = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      wait_ready();
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("t6_drained", 64'(exp_q.size()), 64'(0));
    b2b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial sequencer that drives the team's single-bit full-adder cell to perform WIDTH-bit additions. It accepts two operands and a carry-in over a valid/ready handshake and presents one operand bit pair per cycle, LSB first, to the external full-adder cell. It keeps the ripple carry in a flip-flop between bits, collects the cell's sum bits, and returns the WIDTH-bit sum and final carry over a second valid/ready handshake. It sits directly upstream of the full-adder cell, feeding its a/b/cin inputs, and directly downstream of it, consuming its sum/cout outputs.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-high: rst_n=1 at a rising edge resets the block.
- ena  in  1  global enable; while 0, all state holds and both handshakes are blocked.
- in_valid  in  1  operand request.
- in_ready  out  1  = (state==IDLE) & ena & ~rst_n.
- a  in  WIDTH  operand A; sampled only on an accepted request.
- b  in  WIDTH  operand B; sampled only on an accepted request.
- cin  in  1  carry-in; sampled only on an accepted request.
- out_valid  out  1  = (state==DONE) & ena.
- out_ready  in  1  result consumer ready.
- sum  out  WIDTH  result sum; registered.
- cout  out  1  result carry; registered.
- busy  out  1  = (state!=IDLE).
- fa_a  out  1  to cell a input: A_sh[0] in RUN, else 0.
- fa_b  out  1  to cell b input: B_sh[0] in RUN, else 0.
- fa_cin  out  1  to cell cin input: carry_q in RUN, else 0.
- fa_sum  in  1  from cell sum output; combinational from fa_a/fa_b/fa_cin.
- fa_cout  in  1  from cell cout output; combinational from fa_a/fa_b/fa_cin.

## Operation
- States: IDLE, RUN, DONE. Registers: A_sh, B_sh, S_sh (WIDTH each), carry_q, cnt (ceil(log2 WIDTH) bits), sum, cout.
- Reset: state=IDLE, all registers 0. Outputs after reset: sum=0, cout=0, busy=0, out_valid=0, fa_*=0. in_ready=1 once rst_n=0 and ena=1.
- Behaviour while ena=0: every register holds and no handshake completes.

IDLE
- On in_valid & in_ready: load A_sh=a, B_sh=b, carry_q=cin, cnt=0, S_sh=0; go to RUN.

RUN (each ena=1 edge)
- S_sh <= {fa_sum, S_sh[WIDTH-1:1]}.
- A_sh and B_sh shift right by 1.
- carry_q <= fa_cout; cnt <= cnt+1.
- When cnt==WIDTH-1 at the edge:
  - sum <= {fa_sum, S_sh[WIDTH-1:1]}.
  - cout <= fa_cout.
  - Go to DONE.

DONE
- Hold sum and cout. On out_valid & out_ready, go to IDLE.
- sum and cout keep their last values until the next completion.

Arithmetic and data rules
- Result: {cout,sum} = a + b + cin, exact with no truncation (WIDTH+1 bits).
- Changes on a, b or cin after acceptance have no effect on the operation in progress.

Reset mid-operation
- Synchronous rst_n=1 in RUN or DONE aborts the operation.
- Next cycle: state=IDLE and sum/cout=0.
- No out_valid pulse is produced for the aborted operation.

## Timing
- Acceptance edge E0. RUN occupies edges E1..E_WIDTH.
- out_valid=1 in the cycle after E_WIDTH, i.e. WIDTH cycles after the accept edge (ena=1 throughout).
- Throughput with out_ready=1 and in_valid=1 held: one result per WIDTH+2 cycles:
  - accept edge;
  - WIDTH run edges;
  - release edge, which returns the block to IDLE.
- in_ready is never 1 while busy=1, so there is no same-cycle input/output overlap.
- fa_a and fa_b in RUN cycle k (k=0..WIDTH-1) equal a[k] and b[k]. fa_cin equals the carry out of bit k-1, or cin when k=0.
- ena=0 cycles extend latency one-for-one.
- out_valid stays high until out_ready is sampled 1 with ena=1.

## Test plan
- a=8'h3C, b=8'h42, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h7E, cout=0.
- a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. fa_a sequence over RUN is 0,1,0,1,1,0,1,0 and fa_cin sequence is 1,1,1,1,1,1,1,1.
- a=8'hFF, b=8'h01, cin=0 with out_ready=0 for 5 cycles:
  - out_valid and sum=8'h00, cout=1 held stable all 5 cycles;
  - in_ready=0 throughout;
  - IDLE on the first cycle after out_ready=1.
- ena=0 for 3 cycles in mid-RUN (after bit 3), with a=8'h0F, b=8'h01, cin=0:
  - all fa_* outputs and state frozen during the stall;
  - result sum=8'h10, cout=0 arrives 11 cycles after accept.
- rst_n=1 at RUN bit 4 -> next cycle: busy=0, sum=0, cout=0; no out_valid pulse. A new request a=8'h01, b=8'h01 then yields sum=8'h02.
- Back-to-back requests with out_ready=1 held -> results are spaced exactly 10 cycles apart (WIDTH=8). Each {cout,sum} equals a+b+cin across 200 random operand sets.
